// File: rtl/spi_controller.sv
// SPI mode-0 master: one MSB-first byte per start/busy/done handshake.
// Define SPI_CTRL_BURST_EN to let keep_ss hold ss low across back-to-back bytes.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       keep_ss,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE, LEAD, XFER, TRAIL, GAP, BURST
  } state_e;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ss_q, ss_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        half_end;
  logic        accept;
`ifdef SPI_CTRL_BURST_EN
  logic        keep_q, keep_d;
`else
  logic        unused_keep_ss;
  assign unused_keep_ss = keep_ss;
`endif

  assign half_end = (div_q == DIV_LAST);
`ifdef SPI_CTRL_BURST_EN
  assign accept = start && !busy_q &&
                  (state_q == IDLE || state_q == BURST);
`else
  assign accept = start && !busy_q && (state_q == IDLE);
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
`ifdef SPI_CTRL_BURST_EN
    keep_d    = keep_q;
`endif
    if (state_q != IDLE && state_q != BURST) begin
      div_d = half_end ? '0 : div_q + DW'(1);
    end
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (accept) begin
          tx_d    = tx_data;
          bit_d   = 3'd0;
          div_d   = '0;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          mosi_d  = tx_data[7];
          state_d = LEAD;
`ifdef SPI_CTRL_BURST_EN
          keep_d  = keep_ss;
`endif
        end
      end
      LEAD: begin
        if (half_end) state_d = XFER;
      end
      XFER: begin
        if (half_end) begin
          sclk_d = !sclk_q;
          // falling edge: miso has been stable for the whole high phase
          if (sclk_q) begin
            rx_sh_d = {rx_sh_q[6:0], miso};
            tx_d    = {tx_q[6:0], tx_q[7]};
            mosi_d  = tx_q[6];
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (half_end) begin
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = GAP;
          ss_d      = 1'b1;
          mosi_d    = 1'b0;
`ifdef SPI_CTRL_BURST_EN
          if (keep_q) begin
            state_d = BURST;
            ss_d    = 1'b0;
            busy_d  = 1'b0;
          end
`endif
        end
      end
      GAP: begin
        if (half_end) state_d = IDLE;
      end
      BURST: begin
        ss_d   = 1'b0;
        sclk_d = 1'b0;
        if (accept) begin
          tx_d    = tx_data;
          bit_d   = 3'd0;
          div_d   = '0;
          busy_d  = 1'b1;
          mosi_d  = tx_data[7];
          state_d = XFER;
`ifdef SPI_CTRL_BURST_EN
          keep_d  = keep_ss;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= 3'd0;
      tx_q      <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
`ifdef SPI_CTRL_BURST_EN
      keep_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
`ifdef SPI_CTRL_BURST_EN
      keep_q    <= keep_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ss      = ss_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: table vectors, random frames and corner
// sequences against a behavioural mode-0 peripheral model.
module tb_spi_controller;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       keep_ss;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;

  logic       start1;
  logic [7:0] tx1;
  logic       keep1;
  logic       busy1;
  logic       done1;
  logic [7:0] rx1;
  logic       ss1;
  logic       sclk1;
  logic       mosi1;
  logic       miso1;

  spi_controller #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tx_data(tx_data), .keep_ss(keep_ss),
    .busy(busy), .done(done), .rx_data(rx_data),
    .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_controller #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .tx_data(tx1), .keep_ss(keep1),
    .busy(busy1), .done(done1), .rx_data(rx1),
    .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // peripheral model: 0x8F -> next reply AA, 0x90 -> config byte 1
  logic [31:0] cfg;
  logic [7:0]  dflt_resp;
  logic [7:0]  p_last;
  logic [7:0]  p_sh;
  logic [7:0]  p_rx;
  int          p_bits;
  logic [7:0]  seen[$];

  function automatic logic [7:0] resp_fn(input logic [7:0] prev,
                                         input logic [7:0] dflt);
    if (prev == 8'h8F) return 8'hAA;
    if (prev == 8'h90) return cfg[15:8];
    return dflt;
  endfunction

  always @(posedge sclk or posedge ss) begin
    if (ss) begin
      p_bits = 0;
      miso = 1'b0;
      if (rst) p_last = 8'h00;
    end else begin
      if (p_bits == 0) p_sh = resp_fn(p_last, dflt_resp);
      miso = p_sh[7];
      p_sh = {p_sh[6:0], 1'b0};
      p_rx = {p_rx[6:0], mosi};
      p_bits++;
      if (p_bits == 8) begin
        seen.push_back(p_rx);
        p_last = p_rx;
        p_bits = 0;
      end
    end
  end

  logic [7:0] q_sh;
  logic [7:0] q_rx;
  int         q_bits;

  always @(posedge sclk1 or posedge ss1) begin
    if (ss1) begin
      q_bits = 0;
      miso1 = 1'b0;
    end else begin
      if (q_bits == 0) q_sh = 8'h3C;
      miso1 = q_sh[7];
      q_sh = {q_sh[6:0], 1'b0};
      q_rx = {q_rx[6:0], mosi1};
      q_bits = (q_bits + 1) % 8;
    end
  end

  task automatic run_frame(input logic [7:0] tx,
                           input logic       keep,
                           input logic [7:0] exp_rx,
                           input int         done_e,
                           input int         busy_e,
                           input logic       hammer,
                           input logic       ss_end);
    int e;
    int rises;
    int dones;
    int ss_bad;
    int got_done;
    int got_busy;
    logic prev_sclk;
    logic [7:0] got_tx;
    @(negedge clk);
    start = 1'b1;
    tx_data = tx;
    keep_ss = keep;
    @(negedge clk);
    if (!hammer) start = 1'b0;
    e = 0; rises = 0; dones = 0; ss_bad = 0;
    got_done = -1; got_busy = -1; prev_sclk = 1'b0;
    while (e < 40 * D + 20) begin
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (done) begin
        dones++;
        got_done = e;
        chk("rx_data", rx_data, exp_rx);
      end
      if (e < done_e && ss) ss_bad++;
      if (!busy) begin
        got_busy = e;
        break;
      end
      if (hammer) tx_data = 8'($urandom);
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk("done_edge", got_done, done_e);
    chk("busy_low_edge", got_busy, busy_e);
    chk("done_count", dones, 1);
    chk("sclk_rises", rises, 8);
    chk("ss_low_in_frame", ss_bad, 0);
    chk("ss_at_end", ss, ss_end);
    if (seen.size() > 0) got_tx = seen.pop_front();
    else got_tx = ~tx;
    chk("periph_saw", got_tx, tx);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] dflt;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] prev;
  logic [7:0] r_tx;
  logic [7:0] r_dflt;

  initial begin
    errs = 0;
    checks = 0;
    cfg = 32'h44332211;
    dflt_resp = 8'h3C;
    rst = 1'b1;
    start = 1'b0;
    tx_data = 8'h00;
    keep_ss = 1'b0;
    start1 = 1'b0;
    tx1 = 8'h00;
    keep1 = 1'b0;

    tbl[0] = '{8'hA5, 8'h3C, 8'h3C};
    tbl[1] = '{8'h8F, 8'h11, 8'h11};
    tbl[2] = '{8'h00, 8'h55, 8'hAA};
    tbl[3] = '{8'h90, 8'h66, 8'h66};
    tbl[4] = '{8'h00, 8'h77, 8'h22};
    tbl[5] = '{8'hFF, 8'h00, 8'h00};
    tbl[6] = '{8'h01, 8'h80, 8'h80};

    repeat (3) @(negedge clk);
    chk("rst_ss", ss, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rx", rx_data, 8'h00);
    rst = 1'b0;
    prev = 8'h00;

    // CLK_DIV=1 instance, scenario 1
    begin
      int e;
      int dn;
      int bl;
      int rs;
      logic ps;
      @(negedge clk);
      start1 = 1'b1;
      tx1 = 8'hA5;
      @(negedge clk);
      start1 = 1'b0;
      e = 0; dn = -1; bl = -1; rs = 0; ps = 1'b0;
      while (e < 100) begin
        if (sclk1 && !ps) rs++;
        ps = sclk1;
        if (done1) dn = e;
        if (!busy1) begin
          bl = e;
          break;
        end
        @(negedge clk);
        e++;
      end
      chk("d1_done_edge", dn, 18);
      chk("d1_busy_edge", bl, 20);
      chk("d1_rises", rs, 8);
      chk("d1_rx", rx1, 8'h3C);
      chk("d1_periph_saw", q_rx, 8'hA5);
    end

    for (int i = 0; i < 7; i++) begin
      dflt_resp = tbl[i].dflt;
      run_frame(tbl[i].tx, 1'b0, tbl[i].exp,
                18 * D, 19 * D + 1, 1'b0, 1'b1);
      prev = tbl[i].tx;
    end

    for (int i = 0; i < 12; i++) begin
      r_tx = 8'($urandom);
      r_dflt = 8'($urandom);
      dflt_resp = r_dflt;
      run_frame(r_tx, 1'b0, resp_fn(prev, r_dflt),
                18 * D, 19 * D + 1, 1'b0, 1'b1);
      prev = r_tx;
    end

    // start held high and tx_data churning during the frame
    dflt_resp = 8'h5A;
    run_frame(8'hC3, 1'b0, resp_fn(prev, 8'h5A),
              18 * D, 19 * D + 1, 1'b1, 1'b1);
    prev = 8'hC3;
    @(negedge clk);
    chk("no_reaccept", busy, 1'b0);
    chk("no_extra_frame", seen.size(), 0);

`ifdef SPI_CTRL_BURST_EN
    dflt_resp = 8'h12;
    run_frame(8'h01, 1'b1, resp_fn(prev, 8'h12),
              18 * D, 18 * D, 1'b0, 1'b0);
    chk("burst_ss_held", ss, 1'b0);
    dflt_resp = 8'h34;
    run_frame(8'h02, 1'b0, resp_fn(8'h01, 8'h34),
              17 * D, 18 * D + 1, 1'b0, 1'b1);
    prev = 8'h02;
`else
    dflt_resp = 8'h12;
    run_frame(8'h01, 1'b1, resp_fn(prev, 8'h12),
              18 * D, 19 * D + 1, 1'b0, 1'b1);
    prev = 8'h01;
`endif

    // reset on the 5th falling sclk aborts the frame
    begin
      int e;
      int falls;
      int dn;
      logic ps;
      @(negedge clk);
      start = 1'b1;
      tx_data = 8'h96;
      @(negedge clk);
      start = 1'b0;
      e = 0; falls = 0; dn = 0; ps = 1'b0;
      while (e < 40 * D && falls < 5) begin
        if (!sclk && ps) falls++;
        ps = sclk;
        if (done) dn++;
        if (falls < 5) begin
          @(negedge clk);
          e++;
        end
      end
      chk("abort_reached_fall5", falls, 5);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ss", ss, 1'b1);
      chk("abort_sclk", sclk, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done | (dn != 0), 1'b0);
      chk("abort_rx", rx_data, 8'h00);
      rst = 1'b0;
      chk("abort_no_byte", seen.size(), 0);
      prev = 8'h00;
    end

    dflt_resp = 8'h3C;
    run_frame(8'hA5, 1'b0, 8'h3C,
              18 * D, 19 * D + 1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
